mdu_scheduler: RTL

MDU_SCHEDULER -- requirements
Module: mdu_scheduler

---
 rtl/mdu_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mdu_scheduler.sv
// Multiply/divide unit scheduler: owns HI/LO, runs a fixed-latency mult/div
// countdown and raises a pipeline stall for MDU ops that would collide with it.
module mdu_scheduler #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mdu_op_D,
   input  logic [3:0]  mdu_op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        flush_E,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata_E
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [3:0] MULT_C = 4'(MULT_CYC);
   localparam logic [3:0] DIV_C  = 4'(DIV_CYC);

   localparam logic [3:0] OP_MFHI  = 4'd1;
   localparam logic [3:0] OP_MFLO  = 4'd2;
   localparam logic [3:0] OP_MTHI  = 4'd3;
   localparam logic [3:0] OP_MTLO  = 4'd4;
   localparam logic [3:0] OP_MULT  = 4'd5;
   localparam logic [3:0] OP_MULTU = 4'd6;
   localparam logic [3:0] OP_DIV   = 4'd7;
   localparam logic [3:0] OP_DIVU  = 4'd8;

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;

   logic        is_md_E, is_mdu_D;
   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg;
   logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;

   assign is_md_E  = (mdu_op_E >= OP_MULT) && (mdu_op_E <= OP_DIVU);
   assign is_mdu_D = (mdu_op_D >= OP_MFHI) && (mdu_op_D <= OP_DIVU);

   // Low 64 bits of the product of sign-extended operands equal the signed product.
   assign prod_s = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
   assign prod_u = {32'b0, rs_E} * {32'b0, rt_E};

   // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   assign a_neg   = (mdu_op_E == OP_DIV) && rs_E[31];
   assign b_neg   = (mdu_op_E == OP_DIV) && rt_E[31];
   assign ua      = a_neg ? -rs_E : rs_E;
   assign ub      = b_neg ? -rt_E : rt_E;
   assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
   assign uq      = ua / ub_safe;
   assign ur      = ua % ub_safe;
   assign quo     = (a_neg ^ b_neg) ? -uq : uq;
   assign rem     = a_neg ? -ur : ur;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_n_d  = hi_n_q;
      lo_n_d  = lo_n_q;
      case (state_q)
         S_IDLE: begin
            if (!flush_E) begin
               case (mdu_op_E)
                  OP_MTHI: hi_d = rs_E;
                  OP_MTLO: lo_d = rs_E;
                  OP_MULT: begin
                     hi_n_d = prod_s[63:32];
                     lo_n_d = prod_s[31:0];
                  end
                  OP_MULTU: begin
                     hi_n_d = prod_u[63:32];
                     lo_n_d = prod_u[31:0];
                  end
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero commits the current HI/LO, i.e. no change.
                     hi_n_d = (rt_E == 32'd0) ? hi_q : rem;
                     lo_n_d = (rt_E == 32'd0) ? lo_q : quo;
                  end
                  default: ;
               endcase
               if (is_md_E) begin
                  cnt_d   = (mdu_op_E <= OP_MULTU) ? MULT_C : DIV_C;
                  state_d = S_RUN;
               end
            end
         end
         default: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               hi_d    = hi_n_q;
               lo_d    = lo_n_q;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         hi_n_q  <= 32'd0;
         lo_n_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_n_q  <= hi_n_d;
         lo_n_q  <= lo_n_d;
      end
   end

   assign busy    = (state_q == S_RUN);
   assign stall   = is_mdu_D && (busy || (is_md_E && !flush_E));
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign rdata_E = (mdu_op_E == OP_MFHI) ? hi_q :
                    (mdu_op_E == OP_MFLO) ? lo_q : 32'd0;

endmodule
